// File: rtl/shrg_defs.sv
// Shared definitions for the shrg_seq shift-register command sequencer:
// opcodes, FSM state encoding and the shift-count width helper.
package shrg_defs;

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_LOAD  = 2'd1;
   localparam logic [1:0] OP_SHIFT = 2'd2;
   localparam logic [1:0] OP_SET   = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      ST,
      SH,
      DONE
   } shrg_state_e;

   function automatic int cw_of(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/shrg_seq_cnt.sv
// Loadable down-counter for shift bursts; last_o flags a value of one.
// Load has priority over decrement.
module shrg_seq_cnt #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic [CW-1:0] val_i,
   input  logic          dec_i,
   output logic          last_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (dec_i) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/shrg_seq.sv
// Command sequencer driving an N-bit shift register's control pulses.
// Define SHRG_SEQ_SERIAL_SRC_EN to shift cmd_word out LSB first instead of fill.
module shrg_seq
   import shrg_defs::*;
#(
   parameter int N  = 10,
   parameter int CW = cw_of(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [N-1:0]  cmd_word,
   input  logic [CW-1:0] cmd_cnt,
   input  logic          fill,
   output logic [N-1:0]  sr_i,
   output logic          sr_wri,
   output logic          sr_shift,
   output logic          sr_set,
   output logic          sr_data,
   output logic          busy,
   output logic          done
);

   shrg_state_e   state_q, state_d;
   logic          ready_q;
   logic [N-1:0]  sr_i_q;
   logic          wri_q, shift_q, set_q, data_q;
   logic          busy_q, done_q;
   logic          accept;
   logic          cnt_ld, cnt_dec, cnt_last;
   logic [CW-1:0] k;
   logic          src_bit;

   assign k = (cmd_cnt > CW'(N)) ? CW'(N) : cmd_cnt;

   shrg_seq_cnt #(.CW(CW)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .load_i (cnt_ld),
      .val_i  (k),
      .dec_i  (cnt_dec),
      .last_o (cnt_last)
   );

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      cnt_ld  = 1'b0;
      cnt_dec = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && ready_q) begin
               accept = 1'b1;
               unique case (cmd_op)
                  OP_NOP:  state_d = DONE;
                  OP_LOAD: state_d = WR;
                  OP_SET:  state_d = ST;
                  OP_SHIFT: begin
                     cnt_ld  = 1'b1;
                     state_d = (k == '0) ? DONE : SH;
                  end
               endcase
            end
         end
         WR:   state_d = DONE;
         ST:   state_d = DONE;
         SH: begin
            cnt_dec = 1'b1;
            if (cnt_last) begin
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef SHRG_SEQ_SERIAL_SRC_EN
   logic [N-1:0] shd_q;

   // First bit comes straight from the word; the shadow holds the rest.
   assign src_bit = (state_q == IDLE) ? cmd_word[0] : shd_q[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shd_q <= '0;
      end else if (accept && cmd_op == OP_SHIFT) begin
         shd_q <= cmd_word >> 1;
      end else if (state_q == SH) begin
         shd_q <= shd_q >> 1;
      end
   end
`else
   assign src_bit = fill;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         sr_i_q  <= '0;
         wri_q   <= 1'b0;
         shift_q <= 1'b0;
         set_q   <= 1'b0;
         data_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == IDLE);
         wri_q   <= (state_d == WR);
         shift_q <= (state_d == SH);
         set_q   <= (state_d == ST);
         data_q  <= (state_d == SH) ? src_bit : 1'b0;
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
         if (accept && cmd_op == OP_LOAD) begin
            sr_i_q <= cmd_word;
         end
      end
   end

   assign cmd_ready = ready_q;
   assign sr_i      = sr_i_q;
   assign sr_wri    = wri_q;
   assign sr_shift  = shift_q;
   assign sr_set    = set_q;
   assign sr_data   = data_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_shrg_seq.sv
// Self-checking bench for shrg_seq (N=10) with a command-level reference
// model; define SHRG_SEQ_SERIAL_SRC_EN to check the serial-source build.
module tb_shrg_seq;

   localparam int N  = 10;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [N-1:0]  cmd_word = '0;
   logic [CW-1:0] cmd_cnt = '0;
   logic          fill = 1'b0;
   logic [N-1:0]  sr_i;
   logic          sr_wri, sr_shift, sr_set, sr_data, busy, done;

   int n_cmp = 0;
   int n_err = 0;

   shrg_seq #(.N(N), .CW(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_word  (cmd_word),
      .cmd_cnt   (cmd_cnt),
      .fill      (fill),
      .sr_i      (sr_i),
      .sr_wri    (sr_wri),
      .sr_shift  (sr_shift),
      .sr_set    (sr_set),
      .sr_data   (sr_data),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Observations of one command, filled in by exec.
   int          o_lat, o_shifts, o_wri, o_set, o_dones;
   logic [15:0] o_bits;
   logic [N-1:0] o_sri;
   logic        o_ready_after, o_err;
   logic [N-1:0] exp_sri;

   function automatic int exp_k(input logic [CW-1:0] cnt);
      return (int'(cnt) > N) ? N : int'(cnt);
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [CW-1:0] cnt);
      case (op)
         2'd0:    return 1;
         2'd2:    return exp_k(cnt) + 1;
         default: return 2;
      endcase
   endfunction

   function automatic logic [15:0] exp_bits(input logic [N-1:0] w, input logic [15:0] fb,
                                            input int k);
      logic [15:0] b = '0;
      for (int i = 0; i < k; i++) begin
`ifdef SHRG_SEQ_SERIAL_SRC_EN
         b[i] = w[i];
`else
         b[i] = fb[i];
`endif
      end
      return b;
   endfunction

   // Issue one command from a negedge, observe until done plus one cycle.
   task automatic exec(input logic [1:0] op, input logic [N-1:0] w,
                       input logic [CW-1:0] cnt, input logic [15:0] fb);
      int c = 0;
      o_lat = -1; o_shifts = 0; o_wri = 0; o_set = 0; o_dones = 0;
      o_bits = '0; o_sri = '0; o_ready_after = 1'b0; o_err = 1'b0;
      while (!cmd_ready && c < 20) begin
         @(negedge clk);
         c++;
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_word = w; cmd_cnt = cnt; fill = fb[0];
      @(negedge clk);
      cmd_valid = 1'b0;
      for (c = 1; c <= 20; c++) begin
         if (sr_shift) begin
            if (o_shifts < 16) o_bits[o_shifts] = sr_data;
            o_shifts++;
         end else if (sr_data) begin
            o_err = 1'b1;
         end
         if (sr_wri) begin
            o_wri++;
            o_sri = sr_i;
         end
         if (sr_set) o_set++;
         if (int'(sr_wri) + int'(sr_shift) + int'(sr_set) > 1) o_err = 1'b1;
         if (!busy || cmd_ready) o_err = 1'b1;
         fill = (c < 16) ? fb[c] : 1'b0;
         if (done) begin
            o_lat = c;
            o_dones++;
            @(negedge clk);
            o_ready_after = cmd_ready;
            break;
         end
         @(negedge clk);
      end
      if (op == 2'd1) exp_sri = w;
   endtask

   task automatic check_cmd(input string nm, input logic [1:0] op, input logic [N-1:0] w,
                            input logic [CW-1:0] cnt, input logic [15:0] fb);
      int k;
      logic [15:0] eb;
      k  = (op == 2'd2) ? exp_k(cnt) : 0;
      eb = exp_bits(w, fb, k);
      exec(op, w, cnt, fb);
      n_cmp++;
      if (o_lat !== exp_lat(op, cnt)) begin
         n_err++;
         $display("FAIL %s latency: got %0d want %0d", nm, o_lat, exp_lat(op, cnt));
      end
      n_cmp++;
      if (o_shifts !== k || o_bits !== eb) begin
         n_err++;
         $display("FAIL %s shift: got n=%0d bits=%h want n=%0d bits=%h",
                  nm, o_shifts, o_bits, k, eb);
      end
      n_cmp++;
      if (o_wri !== int'(op == 2'd1) || o_set !== int'(op == 2'd3)) begin
         n_err++;
         $display("FAIL %s pulses: got wri=%0d set=%0d want wri=%0d set=%0d",
                  nm, o_wri, o_set, int'(op == 2'd1), int'(op == 2'd3));
      end
      n_cmp++;
      if (o_err !== 1'b0 || o_ready_after !== 1'b1) begin
         n_err++;
         $display("FAIL %s protocol: got err=%b ready_after=%b want err=0 ready_after=1",
                  nm, o_err, o_ready_after);
      end
      n_cmp++;
      if (sr_i !== exp_sri || (op == 2'd1 && o_sri !== w)) begin
         n_err++;
         $display("FAIL %s sr_i: got %h (at wri %h) want %h", nm, sr_i, o_sri, exp_sri);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      exp_sri = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({sr_i, sr_wri, sr_shift, sr_set, sr_data, busy, done, cmd_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0",
                     {sr_i, sr_wri, sr_shift, sr_set, sr_data, busy, done, cmd_ready});
         end
      end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: got ready=%b busy=%b want ready=1 busy=0",
                  cmd_ready, busy);
      end
   endtask

   task automatic test_load();
      check_cmd("load_010", 2'd1, 10'h010, 4'd0, 16'h0);
   endtask

   task automatic test_shift();
      check_cmd("shift4", 2'd2, 10'h005, 4'd4, 16'b0011);
      check_cmd("shift15", 2'd2, 10'h3a5, 4'd15, 16'h5a5a);
      check_cmd("shift0", 2'd2, 10'h3ff, 4'd0, 16'hffff);
      check_cmd("shift1", 2'd2, 10'h001, 4'd1, 16'h0001);
      check_cmd("shift10", 2'd2, 10'h2cb, 4'd10, 16'h0c3f);
   endtask

   task automatic test_back_to_back();
      int sets = 0, dones = 0, d1 = -1, d2 = -1, acc = -1;
      cmd_valid = 1'b1; cmd_op = 2'd3;
      @(negedge clk);
      cmd_op = 2'd0;
      for (int c = 1; c <= 8; c++) begin
         if (sr_set) sets++;
         if (done) begin
            dones++;
            if (d1 < 0) d1 = c; else d2 = c;
         end
         if (acc < 0 && cmd_valid && cmd_ready) acc = c;
         else if (acc >= 0) cmd_valid = 1'b0;
         @(negedge clk);
      end
      n_cmp++;
      if (sets !== 1 || dones !== 2 || d1 !== 2) begin
         n_err++;
         $display("FAIL b2b_set: got sets=%0d dones=%0d d1=%0d want 1 2 2", sets, dones, d1);
      end
      n_cmp++;
      if (acc !== 3 || d2 !== 4) begin
         n_err++;
         $display("FAIL b2b_nop: got accept=%0d done=%0d want 3 4", acc, d2);
      end
   endtask

   task automatic test_abort();
      int dones = 0;
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_cnt = 4'd8; fill = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({sr_shift, sr_data, busy, cmd_ready, sr_i} !== '0) begin
         n_err++;
         $display("FAIL abort_async: got shift=%b data=%b busy=%b ready=%b sr_i=%h want 0",
                  sr_shift, sr_data, busy, cmd_ready, sr_i);
      end
      exp_sri = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) dones++;
         if (i == 1) reset = 1'b1;
      end
      for (int i = 0; i < 12; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      n_cmp++;
      if (dones !== 0 || cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL abort_nodone: got dones=%0d ready=%b want 0 1", dones, cmd_ready);
      end
      check_cmd("post_abort_load", 2'd1, 10'h2a7, 4'd0, 16'h0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         check_cmd("random", 2'($urandom_range(0, 3)), 10'($urandom),
                   4'($urandom_range(0, 15)), 16'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_shift();
      test_back_to_back();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
